seq_mult_sm: RTL and testbench

Parametrised sequential shift-add multiplier with sign-magnitude handling, a start/busy/done handshake and a run-time signed/unsigned mode. It is the generalised successor of the fixed 4-bit multiplier behind the P01 top level. It sits behind the debounced start input and drives the product/sign display path. One partial-product bit is processed per clock.

---
 rtl/seq_mult_sm_pkg.sv | 16 +
 rtl/seq_mult_sm_ctrl.sv | 86 ++++++++
 rtl/seq_mult_sm.sv | 97 +++++++++
 tb/tb_seq_mult_sm.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_sm_pkg.sv
// Shared types and width helpers for the sequential sign-magnitude multiplier.
package seq_mult_sm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mult_state_e;

    localparam int DW_DEFAULT = 4;

    // Product width for a given operand width.
    function automatic int prod_width(input int dw);
        return 2 * dw;
    endfunction

endpackage

// File: rtl/seq_mult_sm_ctrl.sv
// Control FSM for seq_mult_sm: iteration counter, termination, busy/done.
// Optional feature: SEQ_MULT_EARLY_EXIT_EN ends the run once the remaining
// multiplier bits are all zero.
//
//   state | meaning
//   IDLE  | waiting for start; done may pulse here for one cycle
//   BUSY  | one partial-product bit processed per clock
module seq_mult_sm_ctrl
    import seq_mult_sm_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic rest_zero_i,
    output logic load_o,
    output logic step_o,
    output logic last_o,
    output logic busy_o,
    output logic done_o
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

    mult_state_e    state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d;
    logic           exit_now;

`ifdef SEQ_MULT_EARLY_EXIT_EN
    assign exit_now = rest_zero_i;
`else
    logic unused_rest_zero;
    assign unused_rest_zero = rest_zero_i;
    assign exit_now = 1'b0;
`endif

    // State, counter and done-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state, counter update and datapath strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        load_o  = 1'b0;
        step_o  = 1'b0;
        last_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    load_o  = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                step_o = 1'b1;
                cnt_d  = cnt_q + CW'(1);
                if ((cnt_q == LAST_CNT) || exit_now) begin
                    last_o  = 1'b1;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q == BUSY);
    assign done_o = done_q;

endmodule

// File: rtl/seq_mult_sm.sv
// Sequential shift-add multiplier with sign-magnitude handling and a
// run-time signed/unsigned mode. Optional feature: SEQ_MULT_EARLY_EXIT_EN
// (handled in seq_mult_sm_ctrl) shortens latency for small multipliers.
module seq_mult_sm
    import seq_mult_sm_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_mode,
    input  logic [DW-1:0]     multiplier,
    input  logic [DW-1:0]     multiplicand,
    output logic              busy,
    output logic              done,
    output logic              sign,
    output logic [2*DW-1:0]   product
);

    localparam int PW = prod_width(DW);

    logic          load, step, last;
    logic [DW-1:0] mier_q, mier_d;
    logic [PW-1:0] mcand_q, mcand_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [PW-1:0] prod_q, prod_d;
    logic          opsign_q, opsign_d;
    logic          sign_q, sign_d;
    logic [PW-1:0] acc_sum;

    // Magnitude of an operand; the most negative value maps to 2^(DW-1).
    function automatic logic [DW-1:0] mag(input logic [DW-1:0] x, input logic sm);
        return (sm && x[DW-1]) ? (~x + DW'(1)) : x;
    endfunction

    seq_mult_sm_ctrl #(.DW(DW)) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .rest_zero_i (mier_q[DW-1:1] == '0),
        .load_o      (load),
        .step_o      (step),
        .last_o      (last),
        .busy_o      (busy),
        .done_o      (done)
    );

    assign acc_sum = acc_q + (mier_q[0] ? mcand_q : '0);

    // Operand capture, shift-add iteration and final sign application.
    always_comb begin
        mier_d   = mier_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        opsign_d = opsign_q;
        prod_d   = prod_q;
        sign_d   = sign_q;
        if (load) begin
            mier_d   = mag(multiplier, signed_mode);
            mcand_d  = PW'(mag(multiplicand, signed_mode));
            acc_d    = '0;
            opsign_d = signed_mode & (multiplier[DW-1] ^ multiplicand[DW-1]);
        end else if (step) begin
            acc_d   = acc_sum;
            mier_d  = mier_q >> 1;
            mcand_d = mcand_q << 1;
            if (last) begin
                prod_d = opsign_q ? (~acc_sum + PW'(1)) : acc_sum;
                sign_d = opsign_q & (acc_sum != '0);
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mier_q   <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            opsign_q <= 1'b0;
            prod_q   <= '0;
            sign_q   <= 1'b0;
        end else begin
            mier_q   <= mier_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            opsign_q <= opsign_d;
            prod_q   <= prod_d;
            sign_q   <= sign_d;
        end
    end

    assign product = prod_q;
    assign sign    = sign_q;

endmodule

// File: tb/tb_seq_mult_sm.sv
// Self-checking bench for seq_mult_sm (DW=4) using an expected-result queue.
module tb_seq_mult_sm;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       signed_mode;
    logic [3:0] multiplier;
    logic [3:0] multiplicand;
    logic       busy;
    logic       done;
    logic       sign;
    logic [7:0] product;

    typedef struct {
        logic [7:0] prod;
        logic       sgn;
        int         lat;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    seq_mult_sm #(.DW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .busy         (busy),
        .done         (done),
        .sign         (sign),
        .product      (product)
    );

    // Reference model: full-precision integer multiply, plus latency.
    function automatic exp_t model(input logic [3:0] mr, input logic [3:0] mc,
                                   input logic sm, input string nm);
        exp_t e;
        int a, b, p, m, hb;
        a = sm ? int'($signed(mr)) : int'(mr);
        b = sm ? int'($signed(mc)) : int'(mc);
        p = a * b;
        e.prod = p[7:0];
        e.sgn  = (p < 0);
        e.name = nm;
        m = (a < 0) ? -a : a;
        hb = 0;
        for (int i = 0; i < 4; i++) if (m[i]) hb = i + 1;
`ifdef SEQ_MULT_EARLY_EXIT_EN
        e.lat = (hb < 1) ? 1 : hb;
`else
        e.lat = 4;
`endif
        return e;
    endfunction

    // Waits for done (bounded), checking busy while waiting, then compares
    // against the head of the scoreboard. Called right after edge t0 (+#1).
    task automatic wait_and_check();
        exp_t e;
        int lat;
        lat = 0;
        if (exp_q.size() == 0) begin
            total++;
            $display("FAIL scoreboard_empty: queue size 0, required >0");
            return;
        end
        e = exp_q.pop_front();
        total++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL %s_busy_t0: busy=%b done=%b, required busy=1 done=0", e.name, busy, done);
        else passed++;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!done && busy !== 1'b1) begin
                total++;
                $display("FAIL %s_busy_hold: busy=%b at cycle %0d, required 1", e.name, busy, lat);
            end
        end while (done !== 1'b1 && lat < 20);
        total++;
        if (lat !== e.lat) $display("FAIL %s_latency: got %0d, required %0d", e.name, lat, e.lat);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL %s_busy_at_done: busy=%b, required 0", e.name, busy);
        else passed++;
        total++;
        if (product !== e.prod) $display("FAIL %s_product: got %h, required %h", e.name, product, e.prod);
        else passed++;
        total++;
        if (sign !== e.sgn) $display("FAIL %s_sign: got %b, required %b", e.name, sign, e.sgn);
        else passed++;
    endtask

    task automatic do_op(input logic [3:0] mr, input logic [3:0] mc,
                         input logic sm, input string nm);
        exp_q.push_back(model(mr, mc, sm, nm));
        @(negedge clk);
        start = 1'b1; signed_mode = sm; multiplier = mr; multiplicand = mc;
        @(posedge clk); #1;
        start = 1'b0;
        multiplier = 4'($urandom); multiplicand = 4'($urandom); signed_mode = ~sm;
        wait_and_check();
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0) $display("FAIL %s_done_clear: done=%b, required 0", nm, done);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; signed_mode = 1'b1;
        multiplier = 4'h0; multiplicand = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, done, sign, product} !== 11'd0)
            $display("FAIL reset_outputs: busy=%b done=%b sign=%b product=%h, required all 0",
                     busy, done, sign, product);
        else passed++;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_signed();
        do_op(4'b0111, 4'b1111, 1'b1, "s7xm1");
        do_op(4'b0111, 4'b1100, 1'b1, "s7xm4");
        do_op(4'b1000, 4'b1000, 1'b1, "sm8xm8");
        do_op(4'b0000, 4'b1010, 1'b1, "s0xm6");
        do_op(4'b0001, 4'b0101, 1'b1, "s1x5");
        do_op(4'b1101, 4'b0011, 1'b1, "sm3x3");
    endtask

    task automatic test_unsigned();
        do_op(4'b1111, 4'b1100, 1'b0, "u15x12");
        do_op(4'b1000, 4'b1001, 1'b0, "u8x9");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++)
            do_op(4'($urandom), 4'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(model(4'b0110, 4'b1011, 1'b1, "b2b_first"));
        exp_q.push_back(model(4'b1111, 4'b1111, 1'b0, "b2b_second"));
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b1; multiplier = 4'b0110; multiplicand = 4'b1011;
        @(posedge clk); #1;
        signed_mode = 1'b0; multiplier = 4'b1111; multiplicand = 4'b1111;
        wait_and_check();
        @(posedge clk); #1;
        start = 1'b0;
        wait_and_check();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int seen;
        exp_t e;
        e = model(4'b0101, 4'b0111, 1'b1, "pre_abort");
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b1; multiplier = 4'b0101; multiplicand = 4'b0111;
        @(posedge clk); #1;
        start = 1'b0;
        wait_and_check();
        @(negedge clk);
        start = 1'b1; multiplier = 4'b0111; multiplicand = 4'b0111;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({busy, done, sign, product} !== 11'd0)
            $display("FAIL abort_outputs: busy=%b done=%b sign=%b product=%h, required all 0",
                     busy, done, sign, product);
        else passed++;
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        total++;
        if (seen !== 0) $display("FAIL abort_no_done: activity in %0d cycles, required 0", seen);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_signed();
        test_unsigned();
        test_back_to_back();
        test_reset_abort();
        test_random();
        total++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
